// File: rtl/alu_issue_queue.sv
// ============================================================================
// Module   : alu_issue_queue
// Brief    : Collapsing oldest-first single-issue queue for one ALU lane.
//            Optional macro IQ_EMPTY_BYPASS_EN: empty-queue dispatch-to-issue bypass.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_issue_queue #(
    parameter int DEPTH      = 8,
    parameter int PREG_W     = 6,
    parameter int CTL_W      = 16,
    parameter int WAKE_PORTS = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [63:0]                  disp_pc,
    input  logic [63:0]                  disp_imm,
    input  logic [4:0]                   disp_src1,
    input  logic [4:0]                   disp_src2,
    input  logic [PREG_W-1:0]            disp_psrc1,
    input  logic [PREG_W-1:0]            disp_psrc2,
    input  logic                         disp_rdy1,
    input  logic                         disp_rdy2,
    input  logic                         disp_fwd1,
    input  logic                         disp_fwd2,
    input  logic [PREG_W-1:0]            disp_dst,
    input  logic [CTL_W-1:0]             disp_ctl,
    input  logic [WAKE_PORTS-1:0]        wake_valid,
    input  logic [WAKE_PORTS*PREG_W-1:0] wake_tag,
    input  logic                         iss_stall,
    output logic                         iss_valid,
    output logic [63:0]                  iss_pc,
    output logic [63:0]                  iss_imm,
    output logic [4:0]                   iss_src1,
    output logic [4:0]                   iss_src2,
    output logic [PREG_W-1:0]            iss_psrc1,
    output logic [PREG_W-1:0]            iss_psrc2,
    output logic                         iss_fwd1,
    output logic                         iss_fwd2,
    output logic [PREG_W-1:0]            iss_dst,
    output logic [CTL_W-1:0]             iss_ctl,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [63:0]       pc;
        logic [63:0]       imm;
        logic [4:0]        src1;
        logic [4:0]        src2;
        logic [PREG_W-1:0] psrc1;
        logic [PREG_W-1:0] psrc2;
        logic              fwd1;
        logic              fwd2;
        logic [PREG_W-1:0] dst;
        logic [CTL_W-1:0]  ctl;
    } op_t;

    op_t              r_ent [DEPTH];
    logic [DEPTH-1:0] r_rdy1, r_rdy2;
    logic [CNT_W-1:0] r_count;
    op_t              r_iss;
    logic             r_iss_valid;

    op_t              w_ent_n [DEPTH];
    logic [DEPTH-1:0] w_rdy1_n, w_rdy2_n, w_woke1, w_woke2;
    op_t              w_new, w_sel_ent;
    logic             w_new_r1, w_new_r2;
    logic [CNT_W-1:0] w_sel, w_tail, w_count_n;
    logic             w_found, w_issue, w_accept, w_bypass, w_enq;

    function automatic logic f_match(input logic [PREG_W-1:0]            tag,
                                     input logic [WAKE_PORTS-1:0]        v,
                                     input logic [WAKE_PORTS*PREG_W-1:0] t);
        logic m;
        m = 1'b0;
        for (int k = 0; k < WAKE_PORTS; k++)
            m = m | (v[k] && (t[k*PREG_W +: PREG_W] == tag));
        return m;
    endfunction

    assign disp_ready = (r_count < CNT_W'(DEPTH));

    always_comb begin
        w_new       = '{pc: disp_pc, imm: disp_imm, src1: disp_src1, src2: disp_src2,
                        psrc1: disp_psrc1, psrc2: disp_psrc2, fwd1: disp_fwd1,
                        fwd2: disp_fwd2, dst: disp_dst, ctl: disp_ctl};
        w_new_r1    = disp_rdy1 | f_match(disp_psrc1, wake_valid, wake_tag);
        w_new_r2    = disp_rdy2 | f_match(disp_psrc2, wake_valid, wake_tag);

        // Select uses ready state as registered at the start of the cycle.
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (CNT_W'(i) < r_count && r_rdy1[i] && r_rdy2[i]) begin
                w_found = 1'b1;
                w_sel   = CNT_W'(i);
            end
        end
        w_sel_ent = '0;
        for (int i = 0; i < DEPTH; i++)
            if (w_found && w_sel == CNT_W'(i))
                w_sel_ent = r_ent[i];

        w_issue  = w_found && !iss_stall;
        w_accept = disp_valid && disp_ready;
`ifdef IQ_EMPTY_BYPASS_EN
        w_bypass = w_accept && (r_count == '0) && !iss_stall && w_new_r1 && w_new_r2;
`else
        w_bypass = 1'b0;
`endif
        w_enq    = w_accept && !w_bypass;

        for (int i = 0; i < DEPTH; i++) begin
            w_woke1[i] = r_rdy1[i] | f_match(r_ent[i].psrc1, wake_valid, wake_tag);
            w_woke2[i] = r_rdy2[i] | f_match(r_ent[i].psrc2, wake_valid, wake_tag);
            w_ent_n[i] = r_ent[i];
        end
        w_rdy1_n = w_woke1;
        w_rdy2_n = w_woke2;

        // Collapse everything above the issued slot down by one.
        for (int i = 0; i < DEPTH-1; i++) begin
            if (w_issue && CNT_W'(i) >= w_sel) begin
                w_ent_n[i]  = r_ent[i+1];
                w_rdy1_n[i] = w_woke1[i+1];
                w_rdy2_n[i] = w_woke2[i+1];
            end
        end

        w_tail = r_count - CNT_W'(w_issue);
        for (int i = 0; i < DEPTH; i++) begin
            if (w_enq && w_tail == CNT_W'(i)) begin
                w_ent_n[i]  = w_new;
                w_rdy1_n[i] = w_new_r1;
                w_rdy2_n[i] = w_new_r2;
            end
        end

        w_count_n = r_count + CNT_W'(w_enq) - CNT_W'(w_issue);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count     <= '0;
            r_iss_valid <= 1'b0;
            r_iss       <= '0;
            r_rdy1      <= '0;
            r_rdy2      <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_ent[i] <= '0;
        end else if (flush) begin
            r_count     <= '0;
            r_iss_valid <= 1'b0;
            r_iss       <= '0;
        end else begin
            r_count <= w_count_n;
            r_rdy1  <= w_rdy1_n;
            r_rdy2  <= w_rdy2_n;
            for (int i = 0; i < DEPTH; i++)
                r_ent[i] <= w_ent_n[i];
            if (!iss_stall) begin
                r_iss_valid <= w_found || w_bypass;
                r_iss       <= w_bypass ? w_new : w_sel_ent;
            end
        end
    end

    assign count     = r_count;
    assign iss_valid = r_iss_valid;
    assign iss_pc    = r_iss.pc;
    assign iss_imm   = r_iss.imm;
    assign iss_src1  = r_iss.src1;
    assign iss_src2  = r_iss.src2;
    assign iss_psrc1 = r_iss.psrc1;
    assign iss_psrc2 = r_iss.psrc2;
    assign iss_fwd1  = r_iss.fwd1;
    assign iss_fwd2  = r_iss.fwd2;
    assign iss_dst   = r_iss.dst;
    assign iss_ctl   = r_iss.ctl;

endmodule

`default_nettype wire

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Single-issue, collapsing, oldest-first issue queue for one ALU lane.
- Receives renamed micro-ops from dispatch and tracks operand readiness via physical-tag wakeup broadcasts.
- Selects the oldest ready entry each cycle and registers it into the issue bundle.
- The issue bundle feeds the issue/source pipeline register that drives the register-read (source) stage.

Parameters:
- DEPTH, 8, number of queue entries (power of two not required, >=2)
- PREG_W, 6, physical register tag width
- CTL_W, 16, width of the opaque ALU control field
- WAKE_PORTS, 4, number of wakeup tag broadcast ports

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; discards all entries and the issue register
- disp_valid  in  1  dispatch micro-op present
- disp_ready  out  1  queue can accept (count < DEPTH)
- disp_pc  in  64  instruction PC
- disp_imm  in  64  immediate
- disp_src1, disp_src2  in  5  architectural source registers
- disp_psrc1, disp_psrc2  in  PREG_W  physical source tags
- disp_rdy1, disp_rdy2  in  1  operand already available at dispatch
- disp_fwd1, disp_fwd2  in  1  operand read from PRF (1) or ARF (0); passed through unchanged
- disp_dst  in  PREG_W  physical destination tag
- disp_ctl  in  CTL_W  ALU control
- wake_valid  in  WAKE_PORTS  per-port broadcast valid
- wake_tag  in  WAKE_PORTS*PREG_W  per-port broadcast tag
- iss_stall  in  1  downstream stall; hold issue register
- iss_valid  out  1  issue bundle valid
- iss_pc, iss_imm  out  64  registered copies
- iss_src1, iss_src2  out  5  registered copies
- iss_psrc1, iss_psrc2  out  PREG_W  registered copies
- iss_fwd1, iss_fwd2  out  1  registered copies
- iss_dst  out  PREG_W  registered copy
- iss_ctl  out  CTL_W  registered copy
- count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (resetn low, async):
  - all entry valid bits 0; count=0; iss_valid=0.
  - All iss_* data outputs are 0.
- Entry fields: valid, all disp_* fields, rdy1, rdy2. Entries are held in age order: index 0 is the oldest; valid entries are contiguous from index 0.
- Dispatch: accepted when disp_valid && disp_ready.
  - The new entry is written at the tail (after compaction for any same-cycle issue).
  - rdy1 = disp_rdy1 OR a match of disp_psrc1 against any valid wake port in the same cycle; rdy2 likewise.
- Wakeup: every cycle, each valid entry sets rdy1 (rdy2) when any wake_valid[k] && wake_tag[k]==psrc1 (psrc2). Ready bits never clear except when the entry is removed.
- Select: the lowest-index valid entry with rdy1&&rdy2 is chosen, using ready state at the start of the cycle. Only if !iss_stall.
- Issue register:
  - If !iss_stall: iss_valid <= selected-found; iss_* <= selected fields, or zeros if none found. The selected entry is removed and entries above it shift down by one.
  - If iss_stall: issue register and queue order are held; wakeup and dispatch proceed.
- Latency: an entry dispatched ready in cycle N is selectable in N+1 and appears on iss_valid in N+2 after its selecting edge. A wake-up broadcast in cycle N makes a dependent selectable in N+1.
- Full: disp_ready = (count < DEPTH). disp_ready is combinational on count only, so a same-cycle issue does not free a slot for dispatch.
- Simultaneous issue and dispatch: count is unchanged; order is preserved (the new entry goes to the new tail).
- Flush has priority over everything: next cycle all entries are invalid, count=0, iss_valid=0, and dispatch that cycle is dropped.
- count is always equal to the number of valid entries. count never exceeds DEPTH and never underflows.

Optional Feature:
- Macro: IQ_EMPTY_BYPASS_EN.
- Defined: when the queue is empty and has no pending issue, !iss_stall, and the dispatched op is ready (including same-cycle wakeup), the op is written directly into the issue register in the same cycle and not enqueued. Result: iss_valid one edge after dispatch; count is unchanged.
- Undefined: every op goes through the queue; minimum dispatch-to-issue latency is 2 edges.

Test Plan:
- Reset: hold resetn=0 mid-operation with 3 entries -> count=0, iss_valid=0, all iss_* =0, disp_ready=1 immediately (async).
- Ordering: dispatch A(psrc1=5 not ready), B ready, C ready -> issue order B, C; wake tag 5 -> A issues next; count decrements to 0.
- Fill: dispatch DEPTH=8 ops all not ready -> disp_ready=0 at count=8; a 9th disp_valid is not accepted; wake all -> 8 issues oldest-first.
- Same-cycle wakeup at dispatch: disp_psrc2=9 with rdy2=0 and wake_tag[3]=9 valid in the same cycle -> entry issues 2 edges later without further wakeup.
- Stall: iss_stall=1 for 3 cycles with iss_valid=1, pc=0x80000010 -> outputs held stable, no entry removed; release -> next oldest ready issues.
- Flush: flush=1 with 5 entries and iss_valid=1 plus simultaneous disp_valid -> next cycle count=0, iss_valid=0, the dispatched op is absent.
